// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide engine.
//   md_state_e   : controller state encodings
//   MUL_CNT_W    : width of the multiply latency down-counter
//   mul_cnt_load : counter preload for a given multiply latency
package ex_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_MUL  = 3'd1,
        MD_DIV  = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;

    localparam int MUL_CNT_W = 2;

    // MUL occupies MUL_CYCLES-1 cycles; the counter runs down to zero in that window.
    function automatic int mul_cnt_load(input int mul_cycles);
        return (mul_cycles > 1) ? mul_cycles - 2 : 0;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_div_iter_core.sv
// Magnitude restoring radix-2 divider, one quotient bit per cycle.
// The first quotient bit is produced on the start edge, so N bits take the
// start edge plus N-1 further cycles.
//   clk, rst            clock, async active-high reset
//   start_i             load operands and retire the first quotient bit
//   abort_i             drop the operation in progress
//   n_i                 number of quotient bits (dividend taken from bit n_i-1 down)
//   dividend_i          unsigned dividend (bits above n_i-1 must be zero)
//   divisor_i           unsigned divisor
//   done_o              high in the cycle whose edge retires the final quotient bit
//   quo_o, rem_o        quotient / remainder, valid once the final bit is retired
module div_iter_core #(
    parameter int XLEN = 64,
    parameter int NW   = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [NW-1:0]   n_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rem_o
);

    logic [XLEN-1:0] quo_r, rem_r, dvs_r;
    logic [XLEN-1:0] cur_q, cur_r, cur_d, nxt_q, nxt_r;
    logic [XLEN:0]   rem_shift;
    logic [NW-1:0]   cnt_r;
    logic            active_r, ge;

    // The quotient register doubles as the dividend shifter: dividend bits leave
    // at the top while quotient bits enter at the bottom.
    always_comb begin
        cur_q     = start_i ? (dividend_i << (NW'(XLEN) - n_i)) : quo_r;
        cur_r     = start_i ? '0 : rem_r;
        cur_d     = start_i ? divisor_i : dvs_r;
        rem_shift = {cur_r, cur_q[XLEN-1]};
        ge        = (rem_shift >= {1'b0, cur_d});
        nxt_r     = ge ? XLEN'(rem_shift - {1'b0, cur_d}) : rem_shift[XLEN-1:0];
        nxt_q     = {cur_q[XLEN-2:0], ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quo_r    <= '0;
            rem_r    <= '0;
            dvs_r    <= '0;
            cnt_r    <= '0;
            active_r <= 1'b0;
        end else if (abort_i) begin
            active_r <= 1'b0;
        end else if (start_i) begin
            quo_r    <= nxt_q;
            rem_r    <= nxt_r;
            dvs_r    <= cur_d;
            cnt_r    <= n_i - NW'(1);
            active_r <= 1'b1;
        end else if (active_r) begin
            quo_r <= nxt_q;
            rem_r <= nxt_r;
            cnt_r <= cnt_r - NW'(1);
            if (cnt_r == NW'(1)) active_r <= 1'b0;
        end
    end

    assign done_o = active_r & (cnt_r == NW'(1));
    assign quo_o  = quo_r;
    assign rem_o  = rem_r;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV64M multiply/divide engine serving the EX stage.
// EX issues one request per MUL/DIV/REM op over a valid/ready handshake and
// stalls until the result is returned and accepted.
//   clk, rst                   clock, async active-high reset
//   req_valid_i / req_ready_o  request handshake (ready only in IDLE)
//   mul_en_i                   1 = multiply, 0 = divide/remainder
//   word_i                     *W op: operands from bits [31:0], result sign-extended
//   rs1_sign_i, rs2_sign_i     per-operand signedness
//   rs1_data_i, rs2_data_i     operands
//   flush_i                    abort in-flight op, discard result
//   resp_valid_o / resp_ready_i result handshake, result held until accepted
//   result_lo_o                product low half / quotient
//   result_hi_o                product high half / remainder
//   busy_o                     state != IDLE
//
// state   | meaning
// --------+---------------------------------------------------------
// MD_IDLE | ready for a request
// MD_MUL  | product register settling, latency counter running
// MD_DIV  | divider core retiring one quotient bit per cycle
// MD_FIX  | sign correction / special-case substitution
// MD_DONE | result presented, waiting for resp_ready_i
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_EARLY  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            mul_en_i,
    input  logic            word_i,
    input  logic            rs1_sign_i,
    input  logic            rs2_sign_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_lo_o,
    output logic [XLEN-1:0] result_hi_o,
    output logic            busy_o
);

    localparam int                   NW         = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0]      LOW32      = XLEN'(64'hFFFF_FFFF);
    localparam logic [XLEN-1:0]      DIV_ZERO_Q = '1;
    localparam logic [XLEN-1:0]      MIN_X      = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]      MIN_W      = ~LOW32 | XLEN'(64'h8000_0000);
    localparam logic [MUL_CNT_W-1:0] MUL_LOAD   = MUL_CNT_W'(mul_cnt_load(MUL_CYCLES));

    // Keep bits [31:0], fill the upper bits with bit 31 when sgn is set.
    function automatic logic [XLEN-1:0] ext_word(input logic [XLEN-1:0] v, input logic sgn);
        logic [XLEN-1:0] fill;
        fill = {XLEN{sgn & v[31]}} & ~LOW32;
        return fill | (v & LOW32);
    endfunction

    md_state_e state, state_nxt;

    logic [XLEN-1:0]   a_x, b_x, a_mag, b_mag;
    logic              a_neg, b_neg, div0, ovf, accept, early, div_start;
    logic [2*XLEN-1:0] prod;

    logic              word_r, a_neg_r, b_neg_r, div0_r, ovf_r;
    logic [XLEN-1:0]   a_x_r;
    logic [2*XLEN-1:0] prod_r;
    logic [MUL_CNT_W-1:0] mul_cnt_r;

    logic              div_done;
    logic [XLEN-1:0]   core_q, core_r;
    logic [XLEN-1:0]   q_fix, r_fix, res_lo_nxt, res_hi_nxt;
    logic              load_res;

    // Operand preparation from the request; word ops are widened here so the
    // rest of the datapath only ever sees XLEN-bit values.
    always_comb begin
        a_x    = word_i ? ext_word(rs1_data_i, rs1_sign_i) : rs1_data_i;
        b_x    = word_i ? ext_word(rs2_data_i, rs2_sign_i) : rs2_data_i;
        a_neg  = rs1_sign_i & a_x[XLEN-1];
        b_neg  = rs2_sign_i & b_x[XLEN-1];
        a_mag  = a_neg ? -a_x : a_x;
        b_mag  = b_neg ? -b_x : b_x;
        div0   = (b_x == '0);
        ovf    = rs1_sign_i & rs2_sign_i & (a_x == (word_i ? MIN_W : MIN_X)) & (b_x == '1);
        prod   = {{XLEN{a_neg}}, a_x} * {{XLEN{b_neg}}, b_x};
        accept = req_valid_i & (state == MD_IDLE) & ~flush_i;
        early  = (DIV_EARLY != 0) & (div0 | ovf);
        div_start = accept & ~mul_en_i & ~early;
    end

    div_iter_core #(
        .XLEN (XLEN),
        .NW   (NW)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .abort_i    (flush_i),
        .n_i        (word_i ? NW'(32) : NW'(XLEN)),
        .dividend_i (a_mag),
        .divisor_i  (b_mag),
        .done_o     (div_done),
        .quo_o      (core_q),
        .rem_o      (core_r)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: begin
                if (accept) begin
                    if (mul_en_i)   state_nxt = (MUL_CYCLES == 1) ? MD_DONE : MD_MUL;
                    else if (early) state_nxt = MD_DONE;
                    else            state_nxt = MD_DIV;
                end
            end
            MD_MUL:  if (mul_cnt_r == '0) state_nxt = MD_DONE;
            MD_DIV:  if (div_done) state_nxt = MD_FIX;
            MD_FIX:  state_nxt = MD_DONE;
            MD_DONE: if (resp_ready_i) state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
        if (flush_i) state_nxt = MD_IDLE;
    end

    // Result candidates, selected by the state that is about to enter DONE.
    always_comb begin
        q_fix      = (a_neg_r ^ b_neg_r) ? -core_q : core_q;
        r_fix      = a_neg_r ? -core_r : core_r;
        res_lo_nxt = '0;
        res_hi_nxt = '0;
        case (state)
            MD_IDLE: begin
                if (mul_en_i) begin
                    res_lo_nxt = word_i ? ext_word(prod[XLEN-1:0], 1'b1) : prod[XLEN-1:0];
                    res_hi_nxt = word_i ? ext_word(prod[32 +: XLEN], 1'b1) : prod[2*XLEN-1:XLEN];
                end else begin
                    res_lo_nxt = div0 ? DIV_ZERO_Q : a_x;
                    res_hi_nxt = div0 ? a_x : '0;
                end
            end
            MD_MUL: begin
                res_lo_nxt = word_r ? ext_word(prod_r[XLEN-1:0], 1'b1) : prod_r[XLEN-1:0];
                res_hi_nxt = word_r ? ext_word(prod_r[32 +: XLEN], 1'b1) : prod_r[2*XLEN-1:XLEN];
            end
            MD_FIX: begin
                if (div0_r | ovf_r) begin
                    res_lo_nxt = div0_r ? DIV_ZERO_Q : a_x_r;
                    res_hi_nxt = div0_r ? a_x_r : '0;
                end else begin
                    res_lo_nxt = word_r ? ext_word(q_fix, 1'b1) : q_fix;
                    res_hi_nxt = word_r ? ext_word(r_fix, 1'b1) : r_fix;
                end
            end
            default: ;
        endcase
        load_res = (state_nxt == MD_DONE) & (state != MD_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r      <= 1'b0;
            a_neg_r     <= 1'b0;
            b_neg_r     <= 1'b0;
            div0_r      <= 1'b0;
            ovf_r       <= 1'b0;
            a_x_r       <= '0;
            prod_r      <= '0;
            mul_cnt_r   <= '0;
            result_lo_o <= '0;
            result_hi_o <= '0;
        end else begin
            if (accept) begin
                word_r    <= word_i;
                a_neg_r   <= a_neg;
                b_neg_r   <= b_neg;
                div0_r    <= div0;
                ovf_r     <= ovf;
                a_x_r     <= a_x;
                prod_r    <= prod;
                mul_cnt_r <= MUL_LOAD;
            end else if (state == MD_MUL && mul_cnt_r != '0) begin
                mul_cnt_r <= mul_cnt_r - MUL_CNT_W'(1);
            end
            if (load_res) begin
                result_lo_o <= res_lo_nxt;
                result_hi_o <= res_hi_nxt;
            end
        end
    end

    assign req_ready_o  = (state == MD_IDLE);
    assign resp_valid_o = (state == MD_DONE);
    assign busy_o       = (state != MD_IDLE);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        mul_en;
    logic        word;
    logic        rs1_sign;
    logic        rs2_sign;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] result_lo;
    logic [63:0] result_hi;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc;
    logic seen;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    ex_muldiv_unit #(
        .XLEN       (64),
        .MUL_CYCLES (2),
        .DIV_EARLY  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .mul_en_i     (mul_en),
        .word_i       (word),
        .rs1_sign_i   (rs1_sign),
        .rs2_sign_i   (rs2_sign),
        .rs1_data_i   (rs1_data),
        .rs2_data_i   (rs2_data),
        .flush_i      (flush),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .result_lo_o  (result_lo),
        .result_hi_o  (result_hi),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request on the falling edge; returns #1 after the accept edge (cycle 1).
    task automatic start_op(input logic m, input logic w, input logic s1, input logic s2,
                            input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        check("req_ready before issue", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        mul_en    = m;
        word      = w;
        rs1_sign  = s1;
        rs2_sign  = s2;
        rs1_data  = a;
        rs2_data  = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("busy after accept", 64'(busy), 64'd1);
    endtask

    // Issue and wait for resp_valid; lat is the cycle index with accept at cycle 0.
    task automatic run_op(input logic m, input logic w, input logic s1, input logic s2,
                          input logic [63:0] a, input logic [63:0] b, output int lat);
        start_op(m, w, s1, s2, a, b);
        lat = 1;
        while (!resp_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, " resp_valid after accept"}, 64'(resp_valid), 64'd0);
        check({tag, " req_ready after accept"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; mul_en = 1'b0; word = 1'b0;
        rs1_sign = 1'b0; rs2_sign = 1'b0; rs1_data = '0; rs2_data = '0;
        flush = 1'b0; resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset resp_valid", 64'(resp_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset result_lo", result_lo, 64'd0);
        check("reset result_hi", result_hi, 64'd0);
        rst = 1'b0;

        // signed 7 x -3 = -21
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, cyc);
        check("mul latency", 64'(cyc), 64'd2);
        check("mul lo", result_lo, 64'hFFFF_FFFF_FFFF_FFEB);
        check("mul hi", result_hi, ONES);
        handshake("mul");

        // unsigned all-ones x 2 = 2^65 - 2
        run_op(1'b1, 1'b0, 1'b0, 1'b0, ONES, 64'd2, cyc);
        check("mulhu latency", 64'(cyc), 64'd2);
        check("mulhu lo", result_lo, 64'hFFFF_FFFF_FFFF_FFFE);
        check("mulhu hi", result_hi, 64'd1);
        handshake("mulhu");

        // mulhsu: rs1 = -1 signed, rs2 = 2 unsigned -> -2
        run_op(1'b1, 1'b0, 1'b1, 1'b0, ONES, 64'd2, cyc);
        check("mulhsu lo", result_lo, 64'hFFFF_FFFF_FFFF_FFFE);
        check("mulhsu hi", result_hi, ONES);
        handshake("mulhsu");

        // signed -7 / 2 -> q=-3 r=-1
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, cyc);
        check("div latency", 64'(cyc), 64'd65);
        check("div q", result_lo, 64'hFFFF_FFFF_FFFF_FFFD);
        check("div r", result_hi, ONES);
        handshake("div");

        // signed 7 / -2 -> q=-3 r=1 (remainder follows dividend)
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, cyc);
        check("div neg divisor q", result_lo, 64'hFFFF_FFFF_FFFF_FFFD);
        check("div neg divisor r", result_hi, 64'd1);
        handshake("div2");

        // divuw 0xFFFFFFFF / 1 -> sign-extended all ones
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, cyc);
        check("divuw latency", 64'(cyc), 64'd33);
        check("divuw q", result_lo, ONES);
        check("divuw r", result_hi, 64'd0);
        handshake("divuw");

        // divide by zero, early out
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 64'd5, 64'd0, cyc);
        check("div0 latency", 64'(cyc), 64'd1);
        check("div0 q", result_lo, ONES);
        check("div0 r", result_hi, 64'd5);
        handshake("div0");

        // signed overflow MIN / -1, early out
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0000, ONES, cyc);
        check("ovf latency", 64'(cyc), 64'd1);
        check("ovf q", result_lo, 64'h8000_0000_0000_0000);
        check("ovf r", result_hi, 64'd0);
        handshake("ovf");

        // flush together with a request in IDLE: not accepted
        @(negedge clk);
        req_valid = 1'b1; flush = 1'b1; mul_en = 1'b1;
        rs1_data = 64'd3; rs2_data = 64'd4;
        @(posedge clk);
        #1;
        req_valid = 1'b0; flush = 1'b0;
        check("flush blocks accept busy", 64'(busy), 64'd0);

        // flush at cycle 10 of a divide
        start_op(1'b0, 1'b0, 1'b0, 1'b0, 64'd1000, 64'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy", 64'(busy), 64'd0);
        check("flush resp_valid", 64'(resp_valid), 64'd0);
        check("flush req_ready", 64'(req_ready), 64'd1);
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        check("flushed div never responds", 64'(seen), 64'd0);

        // mul after flush: -5 x 9 = -45
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd9, cyc);
        check("post-flush mul latency", 64'(cyc), 64'd2);
        check("post-flush mul lo", result_lo, 64'hFFFF_FFFF_FFFF_FFD3);
        check("post-flush mul hi", result_hi, ONES);
        handshake("post-flush mul");

        // EX stalled for 5 cycles: response held stable
        run_op(1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7, cyc);
        check("divu latency", 64'(cyc), 64'd65);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall resp_valid", 64'(resp_valid), 64'd1);
            check("stall q", result_lo, 64'd14);
            check("stall r", result_hi, 64'd2);
        end
        handshake("stall");

        // flush in DONE together with resp_ready: both return to IDLE
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 64'd3, 64'd4, cyc);
        check("mul 3x4 lo", result_lo, 64'd12);
        @(negedge clk);
        flush = 1'b1; resp_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; resp_ready = 1'b0;
        check("done flush resp_valid", 64'(resp_valid), 64'd0);
        check("done flush req_ready", 64'(req_ready), 64'd1);

        // async reset in the middle of a divide
        start_op(1'b0, 1'b0, 1'b1, 1'b1, 64'd77, 64'd5);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst mid-div req_ready", 64'(req_ready), 64'd1);
        check("rst mid-div resp_valid", 64'(resp_valid), 64'd0);
        check("rst mid-div busy", 64'(busy), 64'd0);
        check("rst mid-div result_lo", result_lo, 64'd0);
        check("rst mid-div result_hi", result_hi, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // recovery after reset
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 64'd77, 64'd5, cyc);
        check("post-rst div q", result_lo, 64'd15);
        check("post-rst div r", result_hi, 64'd2);
        handshake("post-rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
